pkt_out_arbiter: RTL and testbench
==================================

Name: pkt_out_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single 134-bit output path toward the MUX between two sources.
- Source 0 is the LCM read-reply path; source 1 is the PGM/auxiliary reply path.
- Grants whole packets only: head flit through tail flit, never interleaved.
- Releases a stalled owner by timeout and keeps per-source packet and drop counters readable by the LCM register read block.

Parameters:
- TIMEOUT, 16'd1024, idle cycles a granted source may go without a flit before its grant is revoked.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in0_data  in  134  source 0 flit; [133:132] 01=head, 11=body, 10=tail, 00=single-flit packet
- in0_data_wr  in  1  source 0 flit strobe
- in0_data_valid  in  1  source 0 packet valid flag, qualified by in0_data_valid_wr
- in0_data_valid_wr  in  1  source 0 valid strobe, asserted with the tail flit
- in0_req  in  1  source 0 has a complete packet pending
- in0_data_ready  out  1  source 0 may present a flit this cycle
- in1_data, in1_data_wr, in1_data_valid, in1_data_valid_wr, in1_req, in1_data_ready: same widths and meaning for source 1
- out_data  out  134  registered flit to MUX
- out_data_wr  out  1  output flit strobe
- out_data_valid  out  1  output packet valid flag
- out_data_valid_wr  out  1  output valid strobe
- out_data_ready  in  1  downstream almost-full-style ready
- pkt0_cnt  out  CNT_W  packets forwarded from source 0
- pkt1_cnt  out  CNT_W  packets forwarded from source 1
- drop_cnt  out  CNT_W  flits dropped (strobe without ready)
- timeout_cnt  out  CNT_W  grants revoked by timeout
- clr_stats  in  1  synchronous clear of all four counters

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, last=1 (so source 0 wins first), all outputs and counters 0, both readies 0. Reset mid-packet abandons the packet; no tail is synthesized.
- States: IDLE, BUSY.
- IDLE, one req set: grant that source.
- IDLE, both reqs set: grant the source other than last.
- IDLE, no req: stay in IDLE.
- A grant sets owner, moves to BUSY, and clears the idle timer. Ready stays 0 during the IDLE cycle.
- BUSY: inN_data_ready = (owner==N) & out_data_ready, driven combinationally. The non-owner's ready is always 0.
- A flit is accepted when owner wr & ready. It appears on out_data/out_data_wr exactly 1 cycle later, unmodified. valid/valid_wr are forwarded with the same 1-cycle latency.
- When out_data_ready falls, ready falls in the same cycle. Downstream tolerates the one flit already registered.
- Accepting a flit with [133:132] = 10 or 00 (end of packet):
  - increments pktN_cnt;
  - sets last=owner;
  - returns to IDLE on the next cycle.
- Re-arbitration takes one IDLE cycle, so there is a minimum 1-cycle gap between packets.
- The idle timer increments each BUSY cycle with no accepted flit, whatever the cause (including out_data_ready low), and clears on every accepted flit.
- When timer == TIMEOUT-1: go to IDLE, increment timeout_cnt, set last=owner. The output is not patched.
- A wr from any source while its ready=0 increments drop_cnt; the flit is discarded. If both sources drop in the same cycle, drop_cnt increases by 2.
- Counters saturate at all-ones and do not wrap.
- clr_stats has priority over increments occurring in the same cycle.
- out_data holds its last value when out_data_wr=0. out_data_valid is 0 unless out_data_valid_wr=1.
- A req deasserted while that source is owner is ignored; the grant ends only on tail or timeout.

Test Plan:
- Single source: after reset, in0_req=1 with a 3-flit packet (01,11,10) → ready0 rises 1 cycle after req; out_data_wr high for 3 cycles, each flit 1 cycle after input; pkt0_cnt=1; back to IDLE.
- Fairness: both reqs held, each source sends 4 single-flit (00) packets → output source order 0,1,0,1,0,1,0,1; pkt0_cnt=pkt1_cnt=4.
- Backpressure: out_data_ready low for 5 cycles mid-packet of 6 flits → ready0 low the same cycles; no flits lost; drop_cnt=0; output order intact.
- Illegal write: in1_data_wr pulsed twice while source 0 owns the grant → drop_cnt=2; output contains only source 0 flits.
- Timeout: TIMEOUT=8, source 0 sends its head flit then stalls → grant revoked after 8 idle cycles; timeout_cnt=1; pending source 1 packet granted next.
- Clear and saturation: preload counters to all-ones via forced traffic/force, send one more packet → counters stay all-ones; clr_stats=1 with a simultaneous tail → all counters read 0 the next cycle.

Source files
------------

// File: rtl/pkt_out_arbiter.sv
// pkt_out_arbiter: two-source, packet-granular round-robin arbiter that
// drives the shared 134-bit output path toward the MUX.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   inN_data / _wr            source N flit and flit strobe ([133:132] = flit type)
//   inN_data_valid / _wr      source N packet valid flag and its strobe (sent with tail)
//   inN_req                   source N has a complete packet pending
//   inN_data_ready            source N may present a flit this cycle (combinational)
//   out_data / _wr            registered flit and strobe to the MUX
//   out_data_valid / _wr      registered packet valid flag and strobe
//   out_data_ready            downstream ready (almost-full style)
//   pkt0_cnt, pkt1_cnt        packets forwarded per source
//   drop_cnt                  flits written while not ready
//   timeout_cnt               grants revoked by the idle timer
//   clr_stats                 synchronous clear of all counters
//
// state | meaning
// IDLE  | no grant; arbitrate pending requests (readies held low)
// BUSY  | owner holds the output until its tail flit or an idle timeout

module pkt_out_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1024,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [133:0]     in0_data,
    input  logic             in0_data_wr,
    input  logic             in0_data_valid,
    input  logic             in0_data_valid_wr,
    input  logic             in0_req,
    output logic             in0_data_ready,
    input  logic [133:0]     in1_data,
    input  logic             in1_data_wr,
    input  logic             in1_data_valid,
    input  logic             in1_data_valid_wr,
    input  logic             in1_req,
    output logic             in1_data_ready,
    output logic [133:0]     out_data,
    output logic             out_data_wr,
    output logic             out_data_valid,
    output logic             out_data_valid_wr,
    input  logic             out_data_ready,
    output logic [CNT_W-1:0] pkt0_cnt,
    output logic [CNT_W-1:0] pkt1_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    input  logic             clr_stats
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [15:0]      timer_q, timer_d;
    logic [133:0]     out_data_q, out_data_d;
    logic             out_wr_q, out_wr_d;
    logic             out_valid_q, out_valid_d;
    logic             out_valid_wr_q, out_valid_wr_d;
    logic [CNT_W-1:0] pkt0_q, pkt0_d, pkt1_q, pkt1_d;
    logic [CNT_W-1:0] drop_q, drop_d, tmo_q, tmo_d;

    logic             busy, accept, eop, timeout_hit, drop0, drop1;
    logic [133:0]     own_data;
    logic             own_wr, own_valid, own_valid_wr;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign busy           = (state_q == BUSY);
    assign in0_data_ready = busy & ~owner_q & out_data_ready;
    assign in1_data_ready = busy &  owner_q & out_data_ready;

    assign own_data     = owner_q ? in1_data          : in0_data;
    assign own_wr       = owner_q ? in1_data_wr       : in0_data_wr;
    assign own_valid    = owner_q ? in1_data_valid    : in0_data_valid;
    assign own_valid_wr = owner_q ? in1_data_valid_wr : in0_data_valid_wr;

    // Type bit 132 is clear for both tail (10) and single-flit (00) packets.
    assign accept      = busy & own_wr & out_data_ready;
    assign eop         = accept & ~own_data[132];
    assign timeout_hit = busy & ~accept & (timer_q == TIMEOUT - 16'd1);
    assign drop0       = in0_data_wr & ~in0_data_ready;
    assign drop1       = in1_data_wr & ~in1_data_ready;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        timer_d        = timer_q;
        out_data_d     = accept ? own_data : out_data_q;
        out_wr_d       = accept;
        out_valid_wr_d = accept & own_valid_wr;
        out_valid_d    = accept & own_valid_wr & own_valid;

        case (state_q)
            IDLE: begin
                if (in0_req | in1_req) begin
                    // With both requesting, the source that did not go last wins.
                    owner_d = (in0_req & in1_req) ? ~last_q : in1_req;
                    state_d = BUSY;
                    timer_d = 16'd0;
                end
            end
            BUSY: begin
                if (accept) begin
                    timer_d = 16'd0;
                    if (eop) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_stats) begin
            pkt0_d = '0;
            pkt1_d = '0;
            drop_d = '0;
            tmo_d  = '0;
        end else begin
            pkt0_d = sat_add(pkt0_q, {1'b0, eop & ~owner_q});
            pkt1_d = sat_add(pkt1_q, {1'b0, eop &  owner_q});
            drop_d = sat_add(drop_q, {1'b0, drop0} + {1'b0, drop1});
            tmo_d  = sat_add(tmo_q,  {1'b0, timeout_hit});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            last_q         <= 1'b1;
            timer_q        <= 16'd0;
            out_data_q     <= '0;
            out_wr_q       <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
            pkt0_q         <= '0;
            pkt1_q         <= '0;
            drop_q         <= '0;
            tmo_q          <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            timer_q        <= timer_d;
            out_data_q     <= out_data_d;
            out_wr_q       <= out_wr_d;
            out_valid_q    <= out_valid_d;
            out_valid_wr_q <= out_valid_wr_d;
            pkt0_q         <= pkt0_d;
            pkt1_q         <= pkt1_d;
            drop_q         <= drop_d;
            tmo_q          <= tmo_d;
        end
    end

    assign out_data          = out_data_q;
    assign out_data_wr       = out_wr_q;
    assign out_data_valid    = out_valid_q;
    assign out_data_valid_wr = out_valid_wr_q;
    assign pkt0_cnt          = pkt0_q;
    assign pkt1_cnt          = pkt1_q;
    assign drop_cnt          = drop_q;
    assign timeout_cnt       = tmo_q;

endmodule

// File: tb/tb_pkt_out_arbiter.sv
// Testbench for pkt_out_arbiter: per-source packet queues feed a
// transaction-level reference model; accepted flits are pushed to a
// scoreboard that an independent output monitor drains.

module tb_pkt_out_arbiter;
    localparam logic [15:0] TO   = 16'd8;
    localparam int          CW   = 6;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [133:0]  in0_data, in1_data;
    logic          in0_data_wr, in0_data_valid, in0_data_valid_wr, in0_req, in0_data_ready;
    logic          in1_data_wr, in1_data_valid, in1_data_valid_wr, in1_req, in1_data_ready;
    logic [133:0]  out_data;
    logic          out_data_wr, out_data_valid, out_data_valid_wr, out_data_ready;
    logic [CW-1:0] pkt0_cnt, pkt1_cnt, drop_cnt, timeout_cnt;
    logic          clr_stats;

    always #5 clk = ~clk;

    pkt_out_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in0_data(in0_data), .in0_data_wr(in0_data_wr), .in0_data_valid(in0_data_valid),
        .in0_data_valid_wr(in0_data_valid_wr), .in0_req(in0_req), .in0_data_ready(in0_data_ready),
        .in1_data(in1_data), .in1_data_wr(in1_data_wr), .in1_data_valid(in1_data_valid),
        .in1_data_valid_wr(in1_data_valid_wr), .in1_req(in1_req), .in1_data_ready(in1_data_ready),
        .out_data(out_data), .out_data_wr(out_data_wr), .out_data_valid(out_data_valid),
        .out_data_valid_wr(out_data_valid_wr), .out_data_ready(out_data_ready),
        .pkt0_cnt(pkt0_cnt), .pkt1_cnt(pkt1_cnt), .drop_cnt(drop_cnt),
        .timeout_cnt(timeout_cnt), .clr_stats(clr_stats)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Source packet queues: bit 134 holds the packet valid flag.
    logic [134:0] sq [2][$];
    // Scoreboard entries: {valid, valid_wr, flit}.
    logic [135:0] exp_q [$];
    logic [3:0]   out_log [$];

    // Reference model state
    bit m_busy;
    int m_owner, m_last, m_timer;
    int m_pkt [2];
    int m_drop, m_tmo;

    // Stimulus knobs
    int odr_pct, go_pct, ill_pct, clr_pct, hang_pct, seq;
    int ill_once [2];
    int stall_cnt [2];
    bit stall [2];
    bit sah [2];
    bit clr_once, clr_on_eop;
    bit odr_sched [$];

    function automatic int sat(input int c, input int inc);
        return (c + inc > CMAX) ? CMAX : c + inc;
    endfunction

    function automatic logic [133:0] rand_flit();
        return {$urandom, $urandom, $urandom, $urandom, 6'($urandom)};
    endfunction

    task automatic enq(input int s, input int len);
        logic [1:0]   ty;
        logic [134:0] f;
        for (int i = 0; i < len; i++) begin
            if (len == 1)           ty = 2'b00;
            else if (i == 0)        ty = 2'b01;
            else if (i == len - 1)  ty = 2'b10;
            else                    ty = 2'b11;
            f = {1'($urandom), ty, 4'(s), 16'(seq), $urandom, $urandom, $urandom, 16'($urandom)};
            seq++;
            sq[s].push_back(f);
        end
    endtask

    task automatic cycle();
        bit odr, acc, eop, clr;
        bit rq [2];
        bit rdy [2];
        bit wr [2];
        bit vl [2];
        bit vw [2];
        bit ill;
        logic [133:0] d [2];
        logic [134:0] f;
        int dr, o;
        int pinc [2];
        int tinc;

        if (odr_sched.size() > 0) odr = odr_sched.pop_front();
        else odr = (int'($urandom_range(99)) < odr_pct);
        for (int s = 0; s < 2; s++) begin
            rq[s]  = (sq[s].size() > 0);
            rdy[s] = m_busy && (m_owner == s) && odr;
            wr[s]  = 1'b0;
            vl[s]  = 1'b0;
            vw[s]  = 1'b0;
            d[s]   = rand_flit();
            if (m_busy && m_owner == s && stall_cnt[s] == 0 && int'($urandom_range(99)) < hang_pct)
                stall_cnt[s] = int'($urandom_range(12, 3));
            ill = (ill_once[s] > 0) && m_busy && (m_owner != s);
            if (m_busy && m_owner == s && stall_cnt[s] > 0) begin
                stall_cnt[s]--;
            end else if (rdy[s]) begin
                if (rq[s] && !stall[s] && int'($urandom_range(99)) < go_pct) begin
                    wr[s] = 1'b1;
                    d[s]  = sq[s][0][133:0];
                    vw[s] = (sq[s][0][132] == 1'b0);
                    vl[s] = sq[s][0][134];
                end
            end else if (ill || int'($urandom_range(99)) < ill_pct) begin
                wr[s] = 1'b1;
                vl[s] = 1'($urandom);
                vw[s] = 1'($urandom);
                if (ill) ill_once[s]--;
            end
        end

        acc = m_busy && wr[m_owner] && rdy[m_owner];
        eop = acc && (d[m_owner][132] == 1'b0);
        clr = clr_once || (clr_on_eop && eop) || (int'($urandom_range(99)) < clr_pct);
        clr_once = 1'b0;

        in0_data = d[0]; in0_data_wr = wr[0]; in0_data_valid = vl[0];
        in0_data_valid_wr = vw[0]; in0_req = rq[0];
        in1_data = d[1]; in1_data_wr = wr[1]; in1_data_valid = vl[1];
        in1_data_valid_wr = vw[1]; in1_req = rq[1];
        out_data_ready = odr;
        clr_stats = clr;
        #1;
        chk("in0_data_ready", 134'(in0_data_ready), 134'(rdy[0]));
        chk("in1_data_ready", 134'(in1_data_ready), 134'(rdy[1]));

        dr = 0;
        for (int s = 0; s < 2; s++) if (wr[s] && !rdy[s]) dr++;
        pinc = '{0, 0};
        tinc = 0;
        o = m_owner;
        if (m_busy) begin
            if (acc) begin
                exp_q.push_back({vw[o] && vl[o], vw[o], d[o]});
                f = sq[o].pop_front();
                m_timer = 0;
                if (eop) begin
                    pinc[o] = 1;
                    m_last  = o;
                    m_busy  = 1'b0;
                end else if (sah[o]) begin
                    stall[o] = 1'b1;
                end
            end else if (m_timer == int'(TO) - 1) begin
                tinc   = 1;
                m_last = o;
                m_busy = 1'b0;
                // The revoked source abandons the rest of its packet.
                while (sq[o].size() > 0) begin
                    f = sq[o].pop_front();
                    if (f[132] == 1'b0) break;
                end
                stall[o]     = 1'b0;
                stall_cnt[o] = 0;
            end else begin
                m_timer++;
            end
        end else if (rq[0] || rq[1]) begin
            m_owner = (rq[0] && rq[1]) ? 1 - m_last : (rq[1] ? 1 : 0);
            m_busy  = 1'b1;
            m_timer = 0;
        end

        if (clr) begin
            m_pkt = '{0, 0};
            m_drop = 0;
            m_tmo = 0;
        end else begin
            m_pkt[0] = sat(m_pkt[0], pinc[0]);
            m_pkt[1] = sat(m_pkt[1], pinc[1]);
            m_drop   = sat(m_drop, dr);
            m_tmo    = sat(m_tmo, tinc);
        end

        @(negedge clk);
        chk("pkt0_cnt", 134'(pkt0_cnt), 134'(m_pkt[0]));
        chk("pkt1_cnt", 134'(pkt1_cnt), 134'(m_pkt[1]));
        chk("drop_cnt", 134'(drop_cnt), 134'(m_drop));
        chk("timeout_cnt", 134'(timeout_cnt), 134'(m_tmo));
    endtask

    task automatic drain(input int budget);
        int n;
        bit done;
        n = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || m_busy) && n < budget) begin
            cycle();
            n++;
        end
        done = !(sq[0].size() > 0 || sq[1].size() > 0 || m_busy);
        chk("drain_done", 134'(done), 134'(1));
        cycle();
        cycle();
        chk("scoreboard_empty", 134'(exp_q.size()), 134'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in0_data = '0; in0_data_wr = 0; in0_data_valid = 0; in0_data_valid_wr = 0; in0_req = 0;
        in1_data = '0; in1_data_wr = 0; in1_data_valid = 0; in1_data_valid_wr = 0; in1_req = 0;
        out_data_ready = 0;
        clr_stats = 0;
        @(negedge clk);
        @(negedge clk);
        m_busy = 1'b0; m_owner = 0; m_last = 1; m_timer = 0;
        m_pkt = '{0, 0}; m_drop = 0; m_tmo = 0;
        stall = '{0, 0}; stall_cnt = '{0, 0};
        exp_q.delete();
        sq[0].delete();
        sq[1].delete();
        chk("rst_ready0", 134'(in0_data_ready), 134'(0));
        chk("rst_ready1", 134'(in1_data_ready), 134'(0));
        chk("rst_out_wr", 134'(out_data_wr), 134'(0));
        chk("rst_out_data", out_data, 134'(0));
        chk("rst_out_valid", 134'({out_data_valid, out_data_valid_wr}), 134'(0));
        chk("rst_counters", 134'({pkt0_cnt, pkt1_cnt, drop_cnt, timeout_cnt}), 134'(0));
        rst = 1'b0;
    endtask

    // Output monitor
    initial begin
        logic [135:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (out_data_wr) begin
                    out_log.push_back(out_data[131:128]);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_wr", 134'(out_data_wr), 134'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e[133:0]);
                        chk("out_valid_wr", 134'(out_data_valid_wr), 134'(e[134]));
                        chk("out_valid", 134'(out_data_valid), 134'(e[135]));
                    end
                end else begin
                    chk("idle_out_valid", 134'({out_data_valid, out_data_valid_wr}), 134'(0));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        odr_pct = 100; go_pct = 100; ill_pct = 0; clr_pct = 0; hang_pct = 0; seq = 0;
        ill_once = '{0, 0}; sah = '{0, 0}; clr_once = 0; clr_on_eop = 0;
        do_reset();

        // Single 3-flit packet from source 0
        enq(0, 3);
        drain(100);
        chk("single_pkt0", 134'(pkt0_cnt), 134'(1));

        // Fairness from reset: alternation starting with source 0
        do_reset();
        out_log.delete();
        for (int i = 0; i < 4; i++) begin
            enq(0, 1);
            enq(1, 1);
        end
        drain(200);
        chk("fair_count", 134'(out_log.size()), 134'(8));
        for (int i = 0; i < out_log.size(); i++)
            chk("fair_order", 134'(out_log[i]), 134'(i % 2));
        chk("fair_pkt0", 134'(pkt0_cnt), 134'(4));
        chk("fair_pkt1", 134'(pkt1_cnt), 134'(4));

        // Backpressure: downstream not ready for 5 cycles mid-packet
        clr_once = 1;
        enq(0, 6);
        odr_sched = '{1, 1, 1, 0, 0, 0, 0, 0};
        drain(100);
        chk("bp_drop", 134'(drop_cnt), 134'(0));
        chk("bp_pkt0", 134'(pkt0_cnt), 134'(1));

        // Illegal writes from source 1 while source 0 owns the grant
        clr_once = 1;
        go_pct = 50;
        enq(0, 6);
        ill_once[1] = 2;
        drain(200);
        go_pct = 100;
        chk("illegal_drop", 134'(drop_cnt), 134'(2));
        chk("illegal_pkt1", 134'(pkt1_cnt), 134'(0));

        // Timeout: source 0 stalls after its head flit, source 1 waits
        clr_once = 1;
        enq(0, 4);
        sah[0] = 1;
        cycle();
        enq(1, 2);
        drain(100);
        sah[0] = 0;
        chk("tmo_count", 134'(timeout_cnt), 134'(1));
        chk("tmo_pkt1", 134'(pkt1_cnt), 134'(1));
        chk("tmo_pkt0", 134'(pkt0_cnt), 134'(0));

        // Saturation of all counters, then clear coinciding with a tail
        clr_once = 1;
        ill_pct = 50;
        for (int i = 0; i < 70; i++) enq(0, 1);
        drain(2000);
        ill_pct = 0;
        sah[1] = 1;
        for (int i = 0; i < 66; i++) enq(1, 2);
        drain(2000);
        sah[1] = 0;
        chk("sat_pkt0", 134'(pkt0_cnt), 134'(CMAX));
        chk("sat_drop", 134'(drop_cnt), 134'(CMAX));
        chk("sat_tmo", 134'(timeout_cnt), 134'(CMAX));
        clr_on_eop = 1;
        enq(0, 2);
        drain(50);
        clr_on_eop = 0;
        chk("clr_all", 134'({pkt0_cnt, pkt1_cnt, drop_cnt, timeout_cnt}), 134'(0));

        // Reset in the middle of a packet
        enq(0, 5);
        cycle();
        cycle();
        cycle();
        do_reset();

        // Randomized traffic
        odr_pct = 80; go_pct = 75; ill_pct = 3; clr_pct = 1; hang_pct = 2;
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < 2; s++)
                if (sq[s].size() < 12 && $urandom_range(99) < 15)
                    enq(s, int'($urandom_range(5, 1)));
            cycle();
        end
        ill_pct = 0; clr_pct = 0; hang_pct = 0;
        drain(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
